approx_mult_pipe: RTL and testbench

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

---
 rtl/approx_mult_if.sv | 24 ++
 rtl/approx_mult_pipe.sv | 92 +++++++++
 tb/tb_approx_mult_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/approx_mult_if.sv
// Stream handshake bundle for the approximate multiplier: operand beat in, product beat out.
// The master drives operands and accepts results; the slave is the multiplier.
interface approx_mult_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] z;

    modport master (
        output in_valid, x, y, mode, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, x, y, mode, out_ready,
        output in_ready, out_valid, z
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned multiplier with exact / truncated / truncated+compensated modes.
// Each stage carries the product and its error versus the exact product, and the output side keeps error statistics.
module approx_mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int L      = 4,
    parameter int STAGES = 2,
    parameter int ERR_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_mult_if.slave      bus,
    input  logic              err_clr,
    output logic [ERR_W-1:0]  err_acc,
    output logic [15:0]       beat_cnt
);
    localparam int PW = 2 * WIDTH;
    // Sum width covers both the accumulator and one beat's error plus a carry bit.
    localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 1;
    localparam logic [SW-1:0] ACC_MAX = {{(SW - ERR_W){1'b0}}, {ERR_W{1'b1}}};

    logic          adv;
    logic [PW-1:0] x_ext;
    logic [PW-1:0] y_ext;
    logic [PW-1:0] exact;
    logic [PW-1:0] trunc;
    logic [PW-1:0] comp;
    logic [PW-1:0] z_nxt;
    logic [PW-1:0] err_nxt;

    logic          v_q   [STAGES];
    logic [PW-1:0] z_q   [STAGES];
    logic [PW-1:0] err_q [STAGES];

    logic [SW-1:0] acc_sum;
    logic          out_xfer;

    assign adv           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.z         = z_q[STAGES-1];
    assign out_xfer      = bus.out_valid && bus.out_ready;

    always_comb begin
        x_ext   = PW'(bus.x);
        y_ext   = PW'(bus.y);
        exact   = x_ext * y_ext;
        trunc   = ((x_ext >> L) * y_ext) << L;
        comp    = bus.x[L-1] ? (y_ext << (L - 1)) : '0;
        z_nxt   = exact;
        case (bus.mode)
            2'd1:    z_nxt = trunc;
            2'd2:    z_nxt = trunc + comp;
            default: z_nxt = exact;
        endcase
        err_nxt = exact - z_nxt;
    end

    // A stall freezes every stage at once, so bubbles stay in place rather than collapsing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i]   <= 1'b0;
                z_q[i]   <= '0;
                err_q[i] <= '0;
            end
        end else if (adv) begin
            v_q[0]   <= bus.in_valid;
            z_q[0]   <= z_nxt;
            err_q[0] <= err_nxt;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i]   <= v_q[i-1];
                z_q[i]   <= z_q[i-1];
                err_q[i] <= err_q[i-1];
            end
        end
    end

    assign acc_sum = SW'(err_acc) + SW'(err_q[STAGES-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc  <= '0;
            beat_cnt <= '0;
        end else if (err_clr) begin
            err_acc  <= '0;
            beat_cnt <= '0;
        end else if (out_xfer) begin
            err_acc  <= (acc_sum > ACC_MAX) ? {ERR_W{1'b1}} : acc_sum[ERR_W-1:0];
            beat_cnt <= beat_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe: default instance plus a narrow-accumulator instance for saturation.
module tb_approx_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_clr2 = 1'b0;
    logic [23:0] err_acc;
    logic [15:0] beat_cnt;
    logic [11:0] err_acc2;
    logic [15:0] beat_cnt2;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    approx_mult_if #(.WIDTH(8)) bus ();
    approx_mult_if #(.WIDTH(8)) bus2 ();

    approx_mult_pipe #(.WIDTH(8), .L(4), .STAGES(2), .ERR_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .err_clr(err_clr), .err_acc(err_acc), .beat_cnt(beat_cnt)
    );

    approx_mult_pipe #(.WIDTH(8), .L(4), .STAGES(2), .ERR_W(12)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .err_clr(err_clr2), .err_acc(err_acc2), .beat_cnt(beat_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        bus.in_valid = v;
        bus.x        = a;
        bus.y        = b;
        bus.mode     = m;
    endtask

    initial begin
        int stray;
        beat(1'b0, 8'h00, 8'h00, 2'd0);
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.x         = 8'hFF;
        bus2.y         = 8'hFF;
        bus2.mode      = 2'd1;
        bus2.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_z", 32'(bus.z), 32'd0);
        chk("rst_err_acc", 32'(err_acc), 32'd0);
        chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Three modes back to back, first beat in the very first cycle after reset.
        rst_n = 1'b1;
        beat(1'b1, 8'hFF, 8'hFF, 2'd0);
        step();
        chk("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        beat(1'b1, 8'hFF, 8'hFF, 2'd1);
        step();
        chk("ff_m0_valid", 32'(bus.out_valid), 32'd1);
        chk("ff_m0_z", 32'(bus.z), 32'hFE01);
        beat(1'b1, 8'hFF, 8'hFF, 2'd2);
        step();
        chk("ff_m1_z", 32'(bus.z), 32'hEF10);
        beat(1'b0, 8'h00, 8'h00, 2'd0);
        step();
        chk("ff_m2_z", 32'(bus.z), 32'hF708);
        step();
        chk("ff_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("ff_err_acc", 32'(err_acc), 32'd5610);
        chk("ff_beat_cnt", 32'(beat_cnt), 32'd3);

        // Small operands: truncation drops everything, compensation restores the top dropped term.
        beat(1'b1, 8'h0F, 8'h01, 2'd1);
        step();
        beat(1'b1, 8'h0F, 8'h01, 2'd2);
        step();
        chk("small_m1_z", 32'(bus.z), 32'h0000);
        beat(1'b1, 8'h0F, 8'h01, 2'd3);
        step();
        chk("small_m2_z", 32'(bus.z), 32'h0008);
        beat(1'b0, 8'h00, 8'h00, 2'd0);
        step();
        chk("small_m3_z", 32'(bus.z), 32'h000F);
        step();
        chk("small_err_acc", 32'(err_acc), 32'd5632);
        chk("small_beat_cnt", 32'(beat_cnt), 32'd6);

        // Backpressure: three beats offered while the sink stalls for five cycles.
        bus.out_ready = 1'b0;
        beat(1'b1, 8'd2, 8'd3, 2'd0);
        step();
        chk("bp_ready_a", 32'(bus.in_ready), 32'd1);
        beat(1'b1, 8'd3, 8'd3, 2'd0);
        step();
        chk("bp_ready_b", 32'(bus.in_ready), 32'd0);
        beat(1'b1, 8'd4, 8'd4, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_z", 32'(bus.z), 32'd6);
            chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        beat(1'b0, 8'h00, 8'h00, 2'd0);
        chk("bp_out_b", 32'(bus.z), 32'd9);
        step();
        chk("bp_out_c", 32'(bus.z), 32'd16);
        chk("bp_out_c_valid", 32'(bus.out_valid), 32'd1);
        step();
        chk("bp_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_beat_cnt", 32'(beat_cnt), 32'd9);
        chk("bp_err_acc", 32'(err_acc), 32'd5632);

        // Clear coincides with an output transfer; clear must win.
        beat(1'b1, 8'hFF, 8'hFF, 2'd1);
        step();
        beat(1'b0, 8'h00, 8'h00, 2'd0);
        step();
        chk("clr_xfer_valid", 32'(bus.out_valid), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err_acc", 32'(err_acc), 32'd0);
        chk("clr_beat_cnt", 32'(beat_cnt), 32'd0);

        // Narrow accumulator saturates at 4095 rather than wrapping.
        bus2.in_valid = 1'b1;
        repeat (3) step();
        bus2.in_valid = 1'b0;
        chk("sat_first", 32'(err_acc2), 32'd3825);
        repeat (3) step();
        chk("sat_err_acc", 32'(err_acc2), 32'd4095);
        chk("sat_beat_cnt", 32'(beat_cnt2), 32'd3);

        // Reset with two beats in flight discards both.
        bus.out_ready = 1'b0;
        beat(1'b1, 8'd5, 8'd5, 2'd0);
        step();
        beat(1'b1, 8'd6, 8'd6, 2'd0);
        step();
        beat(1'b0, 8'h00, 8'h00, 2'd0);
        chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_z", 32'(bus.z), 32'd0);
        bus.out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.out_valid) stray++;
        end
        chk("mid_no_stray", 32'(stray), 32'd0);
        chk("mid_beat_cnt", 32'(beat_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
